set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/cache_pkg.sv | 7 +
 rtl/set_assoc_cache_if.sv | 38 +++
 rtl/cache_way_array.sv | 52 +++++
 rtl/set_assoc_cache.sv | 145 ++++++++++++++
 tb/tb_set_assoc_cache.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state encoding and default geometry for set_assoc_cache
package cache_pkg;
   localparam int INDEX_W_DEF = 2;
   localparam int TAG_W_DEF   = 3;
   localparam int DATA_W_DEF  = 3;
   typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, REFILL, RESP} state_t;
endpackage

// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if: request/response and memory-side bundle of set_assoc_cache
//   slave  : the cache (takes req_*, mem_ack, mem_rdata; drives req_ready, resp_*, mem_*)
//   master : the environment driving requests and serving memory
interface set_assoc_cache_if
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = TAG_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [INDEX_W-1:0]       req_index;
   logic [TAG_W-1:0]         req_tag;
   logic [DATA_W-1:0]        req_wdata;
   logic                     resp_valid;
   logic                     resp_hit;
   logic                     resp_wback;
   logic [DATA_W-1:0]        resp_rdata;
   logic                     mem_req;
   logic                     mem_we;
   logic [TAG_W+INDEX_W-1:0] mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic                     mem_ack;
   logic [DATA_W-1:0]        mem_rdata;

   modport slave (
      input  req_valid, req_write, req_index, req_tag, req_wdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_hit, resp_wback, resp_rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output req_valid, req_write, req_index, req_tag, req_wdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_hit, resp_wback, resp_rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_way_array.sv
// cache_way_array: one way of the cache (valid/dirty/tag/data per set)
//   clk, rst   : clock, sync active-high reset (clears valid and dirty only)
//   index_i    : set addressed for both the combinational read and the write
//   *_o        : line contents of the addressed set
//   we_i       : write the addressed line as valid with wr_dirty_i/wr_tag_i/wr_data_i
module cache_way_array
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = TAG_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] index_i,
   output logic               valid_o,
   output logic               dirty_o,
   output logic [TAG_W-1:0]   tag_o,
   output logic [DATA_W-1:0]  data_o,
   input  logic               we_i,
   input  logic               wr_dirty_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [DATA_W-1:0]  wr_data_i
);
   localparam int SETS = 2 ** INDEX_W;
   logic [SETS-1:0]   valid_q, dirty_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [DATA_W-1:0] data_q [SETS];

   assign valid_o = valid_q[index_i];
   assign dirty_o = dirty_q[index_i];
   assign tag_o   = tag_q[index_i];
   assign data_o  = data_q[index_i];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (we_i) begin
         valid_q[index_i] <= 1'b1;
         dirty_q[index_i] <= wr_dirty_i;
      end
   end

   // tag/data are qualified by valid, so they carry no reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[index_i]  <= wr_tag_i;
         data_q[index_i] <= wr_data_i;
      end
   end
endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: 2-way set-associative write-back, write-allocate cache, LRU replacement
//   clock, reset : sole clock, sync active-high reset
//   bus          : request/response handshake and memory-side transaction port
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = TAG_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic clock,
   input  logic reset,
   set_assoc_cache_if.slave bus
);
   localparam int SETS = 2 ** INDEX_W;

   state_t                   state_q;
   logic                     ready_q, resp_valid_q, hit_q, wback_q, write_q, victim_q;
   logic [INDEX_W-1:0]       index_q;
   logic [TAG_W-1:0]         tag_q;
   logic [DATA_W-1:0]        wdata_q, rdata_q;
   logic [SETS-1:0]          lru_q;
   logic                     mem_req_q, mem_we_q;
   logic [TAG_W+INDEX_W-1:0] mem_addr_q;
   logic [DATA_W-1:0]        mem_wdata_q;

   logic [1:0]        v, dt, hw, we;
   logic [TAG_W-1:0]  t   [2];
   logic [DATA_W-1:0] dat [2];
   logic              hit, victim, vdirty, wr_way, line_we, touch;

   for (genvar w = 0; w < 2; w++) begin : g_way
      cache_way_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
         .clk        (clock),
         .rst        (reset),
         .index_i    (index_q),
         .valid_o    (v[w]),
         .dirty_o    (dt[w]),
         .tag_o      (t[w]),
         .data_o     (dat[w]),
         .we_i       (we[w]),
         .wr_dirty_i (write_q),
         .wr_tag_i   (tag_q),
         .wr_data_i  (write_q ? wdata_q : bus.mem_rdata)
      );
      assign hw[w] = v[w] && (t[w] == tag_q);
      assign we[w] = line_we && (wr_way == 1'(w));
   end

   assign hit    = |hw;
   // an empty way is always preferred over evicting; way 0 wins when both are empty
   assign victim = !v[0] ? 1'b0 : !v[1] ? 1'b1 : lru_q[index_q];
   assign vdirty = v[victim] && dt[victim];
   assign wr_way = (state_q == LOOKUP) ? (hit ? hw[1] : victim) : victim_q;
   // a line is written by any write (once any writeback is out of the way) or by a refill
   assign line_we = (state_q == LOOKUP && write_q && (hit || !vdirty))
                 || (state_q == WBACK && bus.mem_ack && write_q)
                 || (state_q == REFILL && bus.mem_ack);
   assign touch   = line_we || (state_q == LOOKUP && hit);

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_hit   = resp_valid_q & hit_q;
   assign bus.resp_wback = resp_valid_q & wback_q;
   assign bus.resp_rdata = resp_valid_q ? rdata_q : '0;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         hit_q        <= 1'b0;
         wback_q      <= 1'b0;
         rdata_q      <= '0;
         lru_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         if (touch) lru_q[index_q] <= ~wr_way;
         case (state_q)
            IDLE: if (bus.req_valid) begin
               write_q <= bus.req_write;
               index_q <= bus.req_index;
               tag_q   <= bus.req_tag;
               wdata_q <= bus.req_wdata;
               ready_q <= 1'b0;
               state_q <= LOOKUP;
            end
            LOOKUP: begin
               hit_q    <= hit;
               wback_q  <= !hit && vdirty;
               victim_q <= victim;
               rdata_q  <= (hit && !write_q) ? dat[hw[1]] : '0;
               if (hit || (write_q && !vdirty)) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
               end else if (vdirty) begin
                  state_q     <= WBACK;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {t[victim], index_q};
                  mem_wdata_q <= dat[victim];
               end else begin
                  state_q    <= REFILL;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= {tag_q, index_q};
               end
            end
            WBACK: if (bus.mem_ack) begin
               mem_we_q    <= 1'b0;
               mem_wdata_q <= '0;
               if (write_q) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  mem_req_q    <= 1'b0;
                  mem_addr_q   <= '0;
               end else begin
                  state_q    <= REFILL;
                  mem_addr_q <= {tag_q, index_q};
               end
            end
            REFILL: if (bus.mem_ack) begin
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               rdata_q      <= bus.mem_rdata;
               mem_req_q    <= 1'b0;
               mem_addr_q   <= '0;
            end
            RESP: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               ready_q      <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed scoreboard bench for set_assoc_cache
module tb_set_assoc_cache;
   localparam int IW = 2, TW = 3, DW = 3;

   typedef struct {
      logic          hit;
      logic          wb;
      logic [DW-1:0] rdata;
   } resp_t;

   typedef struct {
      logic            we;
      logic [TW+IW-1:0] addr;
      logic [DW-1:0]   wdata;
      logic [DW-1:0]   rdata;
      int              delay;
   } mexp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   set_assoc_cache_if #(.INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) bus ();
   set_assoc_cache #(.INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   resp_t rq[$];
   mexp_t mq[$];
   resp_t r;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_resp(logic h, logic wb, logic [DW-1:0] rd);
      rq.push_back('{hit: h, wb: wb, rdata: rd});
   endtask

   task automatic expect_mem(logic we, logic [TW+IW-1:0] a, logic [DW-1:0] wd, logic [DW-1:0] rd, int dly);
      mq.push_back('{we: we, addr: a, wdata: wd, rdata: rd, delay: dly});
   endtask

   task automatic issue(logic w, logic [IW-1:0] idx, logic [TW-1:0] tag, logic [DW-1:0] wd);
      int n = 0;
      @(posedge clk); #1;
      while (!bus.req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_before_issue", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_index = idx;
      bus.req_tag   = tag;
      bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!bus.req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", 32'(bus.req_ready), 1);
   endtask

   // response monitor: every resp_valid pops one expectation
   always @(negedge clk) begin
      if (!rst && bus.resp_valid) begin
         if (rq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got hit=%0b wb=%0b rdata=%0h expected none", bus.resp_hit, bus.resp_wback, bus.resp_rdata);
         end else begin
            r = rq.pop_front();
            chk("resp_hit", 32'(bus.resp_hit), 32'(r.hit));
            chk("resp_wback", 32'(bus.resp_wback), 32'(r.wb));
            chk("resp_rdata", 32'(bus.resp_rdata), 32'(r.rdata));
         end
      end
   end

   // memory responder: checks each pending transaction every cycle, acks after its delay
   initial begin
      int wn = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (rst || !bus.mem_req) wn = 0;
         else if (mq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_mem_req: got addr=%0h we=%0b expected none", bus.mem_addr, bus.mem_we);
         end else begin
            chk("mem_we", 32'(bus.mem_we), 32'(mq[0].we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(mq[0].addr));
            if (mq[0].we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(mq[0].wdata));
            chk("ready_busy", 32'(bus.req_ready), 0);
            if (wn == mq[0].delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mq[0].rdata;
               void'(mq.pop_front());
               wn = 0;
            end else wn++;
         end
      end
   end

   initial begin
      int n;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_index = '0;
      bus.req_tag   = '0;
      bus.req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.req_ready), 1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_resp_hit", 32'(bus.resp_hit), 0);
      chk("rst_resp_wback", 32'(bus.resp_wback), 0);
      chk("rst_resp_rdata", 32'(bus.resp_rdata), 0);
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      rst = 1'b0;

      // cold read miss: refill {5,1}
      expect_mem(1'b0, 5'h15, 3'd0, 3'd3, 0);
      expect_resp(1'b0, 1'b0, 3'd3);
      issue(1'b0, 2'd1, 3'd5, 3'd0);
      wait_idle();

      // read hit: response exactly two cycles after accept, no memory traffic
      expect_resp(1'b1, 1'b0, 3'd3);
      issue(1'b0, 2'd1, 3'd5, 3'd0);
      chk("lookup_no_resp", 32'(bus.resp_valid), 0);
      @(posedge clk); #1;
      chk("hit_resp_latency", 32'(bus.resp_valid), 1);
      wait_idle();

      // write hit dirties way0
      expect_resp(1'b1, 1'b0, 3'd0);
      issue(1'b1, 2'd1, 3'd5, 3'd6);
      wait_idle();

      // fill way1 with tag2
      expect_mem(1'b0, 5'h09, 3'd0, 3'd5, 1);
      expect_resp(1'b0, 1'b0, 3'd5);
      issue(1'b0, 2'd1, 3'd2, 3'd0);
      wait_idle();

      // tag7 evicts dirty LRU way0, then refill held off five cycles
      expect_mem(1'b1, 5'h15, 3'd6, 3'd0, 2);
      expect_mem(1'b0, 5'h1D, 3'd0, 3'd1, 5);
      expect_resp(1'b0, 1'b1, 3'd1);
      issue(1'b0, 2'd1, 3'd7, 3'd0);
      wait_idle();
      chk("mem_queue_drained", 32'(mq.size()), 0);

      // write miss into empty set: allocate without memory traffic
      expect_resp(1'b0, 1'b0, 3'd0);
      issue(1'b1, 2'd2, 3'd3, 3'd4);
      wait_idle();
      expect_resp(1'b1, 1'b0, 3'd4);
      issue(1'b0, 2'd2, 3'd3, 3'd0);
      wait_idle();

      // second write miss takes empty way1
      expect_resp(1'b0, 1'b0, 3'd0);
      issue(1'b1, 2'd2, 3'd1, 3'd2);
      wait_idle();

      // read tag6 must write back way0; reset lands in the WBACK cycle
      issue(1'b0, 2'd2, 3'd6, 3'd0);
      n = 0;
      while (!bus.mem_req && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wback_started", 32'(bus.mem_req), 1);
      chk("wback_we", 32'(bus.mem_we), 1);
      chk("wback_addr", 32'(bus.mem_addr), 32'h0E);
      chk("wback_data", 32'(bus.mem_wdata), 4);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_mem_req", 32'(bus.mem_req), 0);
      chk("abort_ready", 32'(bus.req_ready), 1);
      repeat (5) @(posedge clk);
      #1;

      // contents gone: same tag misses with no writeback
      expect_mem(1'b0, 5'h1A, 3'd0, 3'd2, 0);
      expect_resp(1'b0, 1'b0, 3'd2);
      issue(1'b0, 2'd2, 3'd6, 3'd0);
      wait_idle();
      expect_mem(1'b0, 5'h0E, 3'd0, 3'd7, 0);
      expect_resp(1'b0, 1'b0, 3'd7);
      issue(1'b0, 2'd2, 3'd3, 3'd0);
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      chk("resp_queue_drained", 32'(rq.size()), 0);
      chk("mem_queue_empty", 32'(mq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
